// File: rtl/decode_fwd_stage.sv
// Decode-side operand resolution: bypass-network priority select, late-result
// scoreboard, and a single registered operand stage with valid/ready handshake.
module decode_fwd_stage #(
    parameter int NRP  = 2,
    parameter int NFWD = 4,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NRP*AW-1:0] src_id,
    input  logic [NRP-1:0]    src_en,
    input  logic [NRP*DW-1:0] rf_data,
    input  logic [AW-1:0]     dst_id,
    input  logic              dst_en,
    input  logic              dst_late,
    input  logic [NFWD-1:0]   fwd_valid,
    input  logic [NFWD*AW-1:0] fwd_dst,
    input  logic [NFWD-1:0]   fwd_ok,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic              sb_clr,
    input  logic [AW-1:0]     sb_clr_id,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NRP*DW-1:0] out_val,
    output logic [AW-1:0]     out_dst,
    output logic [15:0]       stall_cnt
);

    localparam int NREG = 1 << AW;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic [NRP-1:0]    used;
    logic [NRP-1:0]    hit;
    logic [NRP-1:0]    hit_ok;
    logic [DW-1:0]     hit_data [NRP];
    logic [NRP-1:0]    hazard;
    logic [NRP*DW-1:0] opnd;
    logic              stall;
    logic              accept;

    logic              vld_p1;
    logic [NRP*DW-1:0] val_p1;
    logic [AW-1:0]     dst_p1;
    logic [15:0]       cnt;

    // Scanning from oldest to youngest lets the youngest match overwrite,
    // so a younger ready writer shadows any older not-yet-computed one.
    always_comb begin
        opnd   = '0;
        hazard = '0;
        for (int i = 0; i < NRP; i++) begin
            hit[i]      = 1'b0;
            hit_ok[i]   = 1'b0;
            hit_data[i] = '0;
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_valid[k] && (fwd_dst[k*AW +: AW] == src_id[i*AW +: AW])) begin
                    hit[i]      = 1'b1;
                    hit_ok[i]   = fwd_ok[k];
                    hit_data[i] = fwd_data[k*DW +: DW];
                end
            end
            used[i] = src_en[i] && (src_id[i*AW +: AW] != '0);
            if (used[i]) begin
                opnd[i*DW +: DW] = hit[i] ? hit_data[i] : rf_data[i*DW +: DW];
                hazard[i]        = hit[i] ? !hit_ok[i] : pend[src_id[i*AW +: AW]];
            end
        end
    end

    assign stall    = |hazard;
    assign in_ready = !stall && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready && !flush;

    // Clear is applied before set so a same-cycle set of the same id wins.
    always_comb begin
        pend_nxt = pend;
        if (sb_clr) begin
            pend_nxt[sb_clr_id] = 1'b0;
        end
        if (accept && dst_en && dst_late && (dst_id != '0)) begin
            pend_nxt[dst_id] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // ---- p1: registered operand stage ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            val_p1 <= '0;
            dst_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            val_p1 <= opnd;
            dst_p1 <= dst_en ? dst_id : '0;
        end else if (vld_p1 && out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (in_valid && stall) begin
            cnt <= sat_inc16(cnt);
        end
    end

    assign out_valid = vld_p1;
    assign out_val   = val_p1;
    assign out_dst   = dst_p1;
    assign stall_cnt = cnt;

endmodule

// File: tb/tb_decode_fwd_stage.sv
// Bench for decode_fwd_stage: vector table plus hand sequences for scoreboard,
// flush and reset corners; output operands checked through a FIFO scoreboard.
module tb_decode_fwd_stage;

    localparam int NRP  = 2;
    localparam int NFWD = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NRP*AW-1:0] src_id;
    logic [NRP-1:0]    src_en;
    logic [NRP*DW-1:0] rf_data;
    logic [AW-1:0]     dst_id;
    logic              dst_en;
    logic              dst_late;
    logic [NFWD-1:0]   fwd_valid;
    logic [NFWD*AW-1:0] fwd_dst;
    logic [NFWD-1:0]   fwd_ok;
    logic [NFWD*DW-1:0] fwd_data;
    logic              sb_clr;
    logic [AW-1:0]     sb_clr_id;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [NRP*DW-1:0] out_val;
    logic [AW-1:0]     out_dst;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    decode_fwd_stage #(.NRP(NRP), .NFWD(NFWD), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .src_id(src_id), .src_en(src_en), .rf_data(rf_data),
        .dst_id(dst_id), .dst_en(dst_en), .dst_late(dst_late),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_ok(fwd_ok), .fwd_data(fwd_data),
        .sb_clr(sb_clr), .sb_clr_id(sb_clr_id), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
        .out_dst(out_dst), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [9:0]   sid;
        logic [1:0]   sen;
        logic [63:0]  rf;
        logic [4:0]   dst;
        logic         den;
        logic         dlate;
        logic [3:0]   fv;
        logic [19:0]  fdst;
        logic [3:0]   fok;
        logic [127:0] fdat;
        logic         stl;
        logic [63:0]  ev;
        logic [4:0]   ed;
    } vec_t;

    logic [68:0] sb [$];
    logic [68:0] mon_e;
    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] en,
                                input logic [31:0] r1, input logic [31:0] r0,
                                input logic [4:0] d, input logic den, input logic dl,
                                input logic [3:0] fv, input logic [19:0] fdst, input logic [3:0] fok,
                                input logic [127:0] fdat, input logic stl,
                                input logic [31:0] e1, input logic [31:0] e0, input logic [4:0] ed);
        vec_t v;
        v.sid = {s1, s0};  v.sen = en;  v.rf = {r1, r0};
        v.dst = d;  v.den = den;  v.dlate = dl;
        v.fv = fv;  v.fdst = fdst;  v.fok = fok;  v.fdat = fdat;
        v.stl = stl;  v.ev = {e1, e0};  v.ed = ed;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        src_id = v.sid;  src_en = v.sen;  rf_data = v.rf;
        dst_id = v.dst;  dst_en = v.den;  dst_late = v.dlate;
        fwd_valid = v.fv;  fwd_dst = v.fdst;  fwd_ok = v.fok;  fwd_data = v.fdat;
        in_valid = 1'b1;
    endtask

    task automatic apply(input vec_t v, input string name);
        drive(v);
        @(negedge clk);
        chk({name, " in_ready"}, {63'd0, in_ready}, {63'd0, !v.stl});
        chk({name, " stall_cnt"}, {48'd0, stall_cnt}, exp_cnt);
        if (!v.stl) sb.push_back({v.ev, v.ed});
        @(posedge clk);
        if (v.stl) exp_cnt++;
        #1;
    endtask

    task automatic idle(input string name);
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, " stall_cnt"}, {48'd0, stall_cnt}, exp_cnt);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got val=%0h dst=%0h expected none", out_val, out_dst);
            end else begin
                mon_e = sb.pop_front();
                chk("out_val", out_val, mon_e[68:5]);
                chk("out_dst", {59'd0, out_dst}, {59'd0, mon_e[4:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rd;
        reset = 1'b1;  in_valid = 1'b0;  src_id = '0;  src_en = '0;  rf_data = '0;
        dst_id = '0;  dst_en = 1'b0;  dst_late = 1'b0;  fwd_valid = '0;  fwd_dst = '0;
        fwd_ok = '0;  fwd_data = '0;  sb_clr = 1'b0;  sb_clr_id = '0;  flush = 1'b0;
        out_ready = 1'b1;

        tbl[0] = mk(5'd4, 5'd3, 2'b11, 32'h22, 32'h11, 5'd1, 1, 0, 4'b0000, 20'd0, 4'b0000,
                    128'd0, 0, 32'h22, 32'h11, 5'd1);
        tbl[1] = mk(5'd0, 5'd3, 2'b11, 32'h0, 32'h77, 5'd2, 1, 0, 4'b0101,
                    {5'd0, 5'd3, 5'd0, 5'd3}, 4'b0101, {32'h0, 32'hB, 32'h0, 32'hA},
                    0, 32'h0, 32'hA, 5'd2);
        tbl[2] = mk(5'd9, 5'd6, 2'b01, 32'h99, 32'h66, 5'd7, 0, 0, 4'b0010,
                    {5'd0, 5'd0, 5'd6, 5'd0}, 4'b0010, {32'h0, 32'h0, 32'h1234, 32'h0},
                    0, 32'h0, 32'h1234, 5'd0);
        tbl[3] = mk(5'd8, 5'd0, 2'b11, 32'h88, 32'h5A, 5'd3, 1, 0, 4'b1001,
                    {5'd8, 5'd0, 5'd0, 5'd0}, 4'b1000, {32'h33, 32'h0, 32'h0, 32'hDEAD},
                    0, 32'h33, 32'h0, 5'd3);
        tbl[4] = mk(5'd3, 5'd3, 2'b11, 32'h1, 32'h2, 5'd4, 1, 0, 4'b0011,
                    {5'd0, 5'd0, 5'd3, 5'd3}, 4'b0001, {32'h0, 32'h0, 32'hBAD, 32'h5},
                    0, 32'h5, 32'h5, 5'd4);
        tbl[5] = mk(5'd12, 5'd3, 2'b11, 32'h0, 32'h0, 5'd4, 1, 0, 4'b0100,
                    {5'd0, 5'd12, 5'd0, 5'd0}, 4'b0000, 128'd0, 1, 32'h0, 32'h0, 5'd4);
        tbl[6] = mk(5'd12, 5'd2, 2'b01, 32'hC, 32'h2, 5'd0, 0, 0, 4'b0100,
                    {5'd0, 5'd12, 5'd0, 5'd0}, 4'b0000, 128'd0, 0, 32'h0, 32'h2, 5'd0);
        tbl[7] = mk(5'd0, 5'd5, 2'b01, 32'h0, 32'h55, 5'd0, 0, 0, 4'b0000,
                    {5'd0, 5'd0, 5'd0, 5'd5}, 4'b0001, {96'd0, 32'hFF}, 0, 32'h0, 32'h55, 5'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset out_val", out_val, 64'd0);
        chk("reset out_dst", {59'd0, out_dst}, 64'd0);
        chk("reset stall_cnt", {48'd0, stall_cnt}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Sustained stall counts every cycle; no count without in_valid.
        for (int i = 0; i < 3; i++) apply(tbl[5], "stall_seq");
        idle("stall_idle");

        // Load-use on r5, released by a scoreboard clear.
        apply(mk(5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 5'd5, 1, 1, 4'b0000, 20'd0, 4'b0000,
                 128'd0, 0, 32'h0, 32'h0, 5'd5), "lw_r5");
        rd = mk(5'd0, 5'd5, 2'b01, 32'h0, 32'h55, 5'd0, 0, 0, 4'b0000, 20'd0, 4'b0000,
                128'd0, 1, 32'h0, 32'h0, 5'd0);
        apply(rd, "use_r5_a");
        apply(rd, "use_r5_b");
        sb_clr = 1'b1;  sb_clr_id = 5'd5;
        apply(rd, "use_r5_clr");
        sb_clr = 1'b0;
        rd.stl = 1'b0;  rd.ev = {32'h0, 32'h55};
        apply(rd, "use_r5_go");

        // Same-cycle set and clear of r7: set wins.
        sb_clr = 1'b1;  sb_clr_id = 5'd7;
        apply(mk(5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 5'd7, 1, 1, 4'b0000, 20'd0, 4'b0000,
                 128'd0, 0, 32'h0, 32'h0, 5'd7), "lw_r7_clr");
        sb_clr = 1'b0;
        rd = mk(5'd0, 5'd7, 2'b01, 32'h0, 32'h77, 5'd0, 0, 0, 4'b0000, 20'd0, 4'b0000,
                128'd0, 1, 32'h0, 32'h0, 5'd0);
        apply(rd, "use_r7_pend");
        sb_clr = 1'b1;
        apply(rd, "use_r7_clr");
        sb_clr = 1'b0;
        rd.stl = 1'b0;  rd.ev = {32'h0, 32'h77};
        apply(rd, "use_r7_go");

        // Flush of a held output, then flush overriding an accept.
        idle("pre_flush");
        out_ready = 1'b0;
        apply(mk(5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 5'd1, 1, 0, 4'b0000, 20'd0, 4'b0000,
                 128'd0, 0, 32'h0, 32'h0, 5'd1), "held");
        in_valid = 1'b0;
        @(negedge clk);
        chk("held out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush out_valid", {63'd0, out_valid}, 64'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(mk(5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 5'd9, 1, 1, 4'b0000, 20'd0, 4'b0000,
                 128'd0, 0, 32'h0, 32'h0, 5'd9));
        flush = 1'b1;
        @(negedge clk);
        chk("flush_acc in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        apply(mk(5'd0, 5'd9, 2'b01, 32'h0, 32'h99, 5'd0, 0, 0, 4'b0000, 20'd0, 4'b0000,
                 128'd0, 0, 32'h0, 32'h99, 5'd0), "use_r9_nopend");

        // Asynchronous reset in the middle of a scoreboard stall.
        idle("pre_reset");
        out_ready = 1'b0;
        apply(mk(5'd0, 5'd0, 2'b00, 32'h0, 32'h0, 5'd10, 1, 1, 4'b0000, 20'd0, 4'b0000,
                 128'd0, 0, 32'h0, 32'h0, 5'd10), "lw_r10");
        rd = mk(5'd0, 5'd10, 2'b01, 32'h0, 32'hAA, 5'd0, 0, 0, 4'b0000, 20'd0, 4'b0000,
                128'd0, 1, 32'h0, 32'h0, 5'd0);
        apply(rd, "use_r10_stall");
        drive(rd);
        #2;
        reset = 1'b1;
        #1;
        chk("async out_valid", {63'd0, out_valid}, 64'd0);
        chk("async out_val", out_val, 64'd0);
        chk("async out_dst", {59'd0, out_dst}, 64'd0);
        chk("async stall_cnt", {48'd0, stall_cnt}, 64'd0);
        exp_cnt = 0;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        rd.stl = 1'b0;  rd.ev = {32'h0, 32'hAA};
        apply(rd, "post_reset");

        repeat (3) idle("drain");
        chk("sb_drain", sb.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_fwd_stage.md
DECODE_FWD_STAGE -- requirements
Module: decode_fwd_stage

Interface
REQ-001 SHALL have parameters, one per line:
- NRP, 2, number of source-operand read ports
- NFWD, 4, number of bypass sources; index 0 is youngest and highest priority
- DW, 32, data width
- AW, 5, register-id width; register 0 is hardwired zero
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock
- reset  in  1  async active-high reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  instruction accepted this cycle
- src_id  in  NRP*AW  source register ids
- src_en  in  NRP  source port used
- rf_data  in  NRP*DW  register-file read data per port
- dst_id  in  AW  destination register
- dst_en  in  1  instruction writes dst_id
- dst_late  in  1  result produced later than execute (load, mult/div)
- fwd_valid  in  NFWD  bypass source holds a live writer
- fwd_dst  in  NFWD*AW  bypass destination id
- fwd_ok  in  NFWD  bypass value already computed
- fwd_data  in  NFWD*DW  bypass value
- sb_clr  in  1  late result written back
- sb_clr_id  in  AW  register whose late result completed
- flush  in  1  squash output register
- out_valid  out  1  operands held
- out_ready  in  1  downstream takes operands
- out_val  out  NRP*DW  resolved operands
- out_dst  out  AW  registered destination (0 when dst_en=0)
- stall_cnt  out  16  operand-stall cycle counter
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-high, named reset.

Function
REQ-004 Per port i, the operand SHALL be 0 when src_en[i]=0 or src_id[i]=0.
REQ-005 Otherwise the operand SHALL be fwd_data[k] for the lowest k with fwd_valid[k] and fwd_dst[k]==src_id[i].
REQ-006 If no bypass source matches, the operand SHALL be rf_data[i].
REQ-007 A port SHALL be hazarded if the lowest matching k has fwd_ok[k]=0.
REQ-008 A port SHALL also be hazarded if no source matches and pend[src_id[i]]=1.
REQ-009 A port SHALL NOT be hazarded by an older fwd_ok=0 match that is shadowed by a younger ok match.
REQ-010 stall SHALL equal OR of hazards over enabled ports with nonzero id; in_ready SHALL equal !stall && (!out_valid || out_ready).
REQ-011 Accept SHALL be in_valid && in_ready; on accept, out_val/out_dst SHALL load next edge and out_valid SHALL become 1 (latency 1 cycle).
REQ-012 If out_valid && out_ready && no accept, out_valid SHALL clear; otherwise the output register SHALL hold.
REQ-013 pend SHALL be an AW-indexed bit vector; on accept with dst_en && dst_late && dst_id!=0, pend[dst_id] SHALL set.
REQ-014 sb_clr SHALL clear pend[sb_clr_id]; on same-cycle set and clear of one id, set SHALL win; pend[0] SHALL stay 0.
REQ-015 flush SHALL clear out_valid next edge, override accept, and leave pend unchanged.
REQ-016 stall_cnt SHALL increment each cycle in_valid && stall, saturate at 0xFFFF, and never wrap.
REQ-017 No combinational path SHALL exist from out_ready to out_val.

Reset
REQ-018 While reset=1, out_valid, out_val, out_dst, pend, and stall_cnt SHALL be 0, immediately and asynchronously.
REQ-019 Reset deassertion mid-stall SHALL restart with pend empty; the first edge after deassertion MAY accept.

Verification
REQ-020 The bench SHALL cover:
- src_id={3,4}, rf_data={0x11,0x22}, no fwd -> next cycle out_val={0x11,0x22}, out_valid=1.
- fwd0 and fwd2 both target r3, ok, data 0xA/0xB -> port value 0xA.
- fwd0 targets r3 with ok=0, older fwd1 r3 ok -> in_ready=0, stall_cnt +1 per cycle.
- Accept lw r5 (dst_late); next instr reads r5, no fwd -> stall until sb_clr r5, then in_ready=1 next cycle.
- Same-cycle accept setting pend[7] and sb_clr r7 -> pend[7]=1.
- out_valid=1, out_ready=0, flush=1 -> out_valid=0 next edge; src r0 with fwd to r0 -> operand 0, no stall.
